spmv_csr_engine: RTL

//  Parametrised CSR sparse-matrix x dense-vector engine (y = A*x): next generation of the SpMV top.

---
 rtl/spmv_pkg.sv | 19 +
 rtl/spmv_sdp_ram.sv | 28 ++
 rtl/spmv_csr_engine.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// Shared encodings for the CSR SpMV engine: load-target selects and FSM states.
package spmv_pkg;

    localparam logic [1:0] SEL_VAL = 2'd0;
    localparam logic [1:0] SEL_COL = 2'd1;
    localparam logic [1:0] SEL_PTR = 2'd2;
    localparam logic [1:0] SEL_X   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPtr0,
        StPtr1,
        StChk,
        StMac,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/spmv_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output (latency 1).
module spmv_sdp_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb rdata_d = mem[raddr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spmv_csr_engine.sv
// CSR sparse-matrix x dense-vector engine: loads A/x into RAMs, then emits one dot product per row.
module spmv_csr_engine
    import spmv_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ACC_W     = 64,
    parameter int unsigned NNZ_AW    = 14,
    parameter int unsigned ROW_AW    = 10,
    parameter int unsigned COL_AW    = 10,
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [1:0]        ld_sel,
    input  logic [NNZ_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [ROW_AW:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ROW_AW-1:0] res_row,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_zero,
    output logic              ptr_err
);

    localparam int unsigned PTR_W = NNZ_AW + 1;
    localparam logic [DATA_W-1:0] MAX_NNZ = {{(DATA_W-1){1'b0}}, 1'b1} << NNZ_AW;

    state_e              state_q, state_d;
    logic [ROW_AW:0]     row_q, row_d;
    logic [ROW_AW:0]     nrows_q, nrows_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [PTR_W-1:0]    hi_q, hi_d;
    logic [PTR_W-1:0]    k_q, k_d;
    logic                v1_q, v1_d;
    logic                v2_q, v2_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                empty_q, empty_d;
    logic                ptr_err_q, ptr_err_d;

    logic                ld_fire;
    logic [ROW_AW:0]     row_nxt;
    logic [ROW_AW:0]     ptr_raddr;
    logic [DATA_W-1:0]   val_rdata;
    logic [COL_AW-1:0]   col_rdata;
    logic [DATA_W-1:0]   ptr_rdata;
    logic [DATA_W-1:0]   x_rdata;
    logic                ptr_bad;
    logic signed [2*DATA_W-1:0] prod;

    assign ld_fire   = ld_valid && ld_ready;
    assign row_nxt   = row_q + 1'b1;
    assign ptr_raddr = (state_q == StPtr1) ? row_nxt : row_q;
    assign ptr_bad   = (ptr_rdata < lo_q) || (ptr_rdata > MAX_NNZ);
    assign prod      = $signed(val_q) * $signed(x_rdata);

    spmv_sdp_ram #(.DW(DATA_W), .AW(NNZ_AW)) u_val_ram (
        .clk_i   (clk),
        .we_i    (ld_fire && (ld_sel == SEL_VAL)),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .raddr_i (k_q[NNZ_AW-1:0]),
        .rdata_o (val_rdata)
    );

    spmv_sdp_ram #(.DW(COL_AW), .AW(NNZ_AW)) u_col_ram (
        .clk_i   (clk),
        .we_i    (ld_fire && (ld_sel == SEL_COL)),
        .waddr_i (ld_addr),
        .wdata_i (ld_data[COL_AW-1:0]),
        .raddr_i (k_q[NNZ_AW-1:0]),
        .rdata_o (col_rdata)
    );

    spmv_sdp_ram #(.DW(DATA_W), .AW(ROW_AW + 1)) u_ptr_ram (
        .clk_i   (clk),
        .we_i    (ld_fire && (ld_sel == SEL_PTR)),
        .waddr_i (ld_addr[ROW_AW:0]),
        .wdata_i (ld_data),
        .raddr_i (ptr_raddr),
        .rdata_o (ptr_rdata)
    );

    spmv_sdp_ram #(.DW(DATA_W), .AW(COL_AW)) u_x_ram (
        .clk_i   (clk),
        .we_i    (ld_fire && (ld_sel == SEL_X)),
        .waddr_i (ld_addr[COL_AW-1:0]),
        .wdata_i (ld_data),
        .raddr_i (col_rdata),
        .rdata_o (x_rdata)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        nrows_d   = nrows_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        k_d       = k_q;
        empty_d   = empty_q;
        ptr_err_d = ptr_err_q;
        v1_d      = 1'b0;
        v2_d      = v1_q;
        val_d     = val_rdata;
        acc_d     = acc_q;
        // Pipeline: issue k -> value/column -> x -> accumulate.
        if (v2_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ptr_err_d = 1'b0;
                    nrows_d   = num_rows;
                    row_d     = '0;
                    state_d   = (num_rows == '0) ? StDone : StPtr0;
                end
            end
            StPtr0: begin
                acc_d   = '0;
                state_d = StPtr1;
            end
            StPtr1: begin
                lo_d    = ptr_rdata;
                state_d = StChk;
            end
            StChk: begin
                empty_d = ptr_bad || (ptr_rdata == lo_q);
                hi_d    = ptr_rdata[PTR_W-1:0];
                k_d     = lo_q[PTR_W-1:0];
                if (ptr_bad) begin
                    ptr_err_d = 1'b1;
                end
                if (!(ptr_bad || (ptr_rdata == lo_q))) begin
                    state_d = StMac;
                end else if (SKIP_ZERO == 0) begin
                    state_d = StEmit;
                end else if (row_nxt < nrows_q) begin
                    row_d   = row_nxt;
                    state_d = StPtr0;
                end else begin
                    state_d = StDone;
                end
            end
            StMac: begin
                if (k_q != hi_q) begin
                    v1_d = 1'b1;
                    k_d  = k_q + 1'b1;
                end else if (!v1_q && !v2_q) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (res_ready) begin
                    if (row_nxt < nrows_q) begin
                        row_d   = row_nxt;
                        state_d = StPtr0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            row_q     <= '0;
            nrows_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            k_q       <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            val_q     <= '0;
            acc_q     <= '0;
            empty_q   <= 1'b0;
            ptr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            nrows_q   <= nrows_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            k_q       <= k_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            val_q     <= val_d;
            acc_q     <= acc_d;
            empty_q   <= empty_d;
            ptr_err_q <= ptr_err_d;
        end
    end

    // busy excludes StDone so that done coincides with busy falling.
    assign ld_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);
    assign res_valid = (state_q == StEmit);
    assign res_row   = row_q[ROW_AW-1:0];
    assign res_data  = acc_q;
    assign res_zero  = empty_q;
    assign ptr_err   = ptr_err_q;

endmodule
